// File: rtl/mem_responder.sv
// CPU bus memory responder: word RAM plus an MMIO page holding
// a console TX byte FIFO and a free-running cycle counter.
module mem_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_address_bus,
    input  logic        in_mem_write_en,
    input  logic [31:0] in_mem_write_data,
    output logic [31:0] out_mem_read_data,
    output logic        out_con_valid,
    output logic [7:0]  out_con_data,
    input  logic        in_con_ready,
    output logic        out_bus_error
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [29:0] MMIO_WI = MMIO_BASE[31:2];

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          ovf;
    logic [31:0]   cycle_cnt;
    logic          bus_err;

    logic [29:0]   word_idx;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          data_hit;
    logic          stat_hit;
    logic          cyc_hit;
    logic          unmapped;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          accept;
    logic [7:0]    cnt8;
    logic [31:0]   stat_word;

    assign word_idx = in_address_bus[31:2];
    assign ram_idx  = in_address_bus[AW+1:2];
    assign ram_hit  = (in_address_bus[31:AW+2] == '0);
    assign data_hit = (word_idx == MMIO_WI);
    assign stat_hit = (word_idx == MMIO_WI + 30'd1);
    assign cyc_hit  = (word_idx == MMIO_WI + 30'd2);
    assign unmapped = !(ram_hit || data_hit || stat_hit || cyc_hit);

    assign empty  = (count == '0);
    assign full   = (count == CW'(FIFO_DEPTH));
    assign push   = in_mem_write_en && data_hit;
    assign pop    = !empty && in_con_ready;
    // A full FIFO still takes a byte when the head leaves on the same edge
    assign accept = push && (!full || pop);

    assign cnt8      = 8'(count);
    assign stat_word = {16'b0, cnt8, 5'b0, ovf, empty, full};

    assign out_con_valid = !empty;
    assign out_con_data  = empty ? 8'h00 : fifo_mem[head];
    assign out_bus_error = bus_err;

    always_comb begin
        out_mem_read_data = 32'h0;
        unique case (1'b1)
            ram_hit:  out_mem_read_data = ram[ram_idx];
            stat_hit: out_mem_read_data = stat_word;
            cyc_hit:  out_mem_read_data = cycle_cnt;
            default:  out_mem_read_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_mem_write_en && ram_hit)
            ram[ram_idx] <= in_mem_write_data;
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifo_mem[tail] <= in_mem_write_data[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept)
                tail <= tail + PW'(1);
            if (pop)
                head <= head + PW'(1);
            if (accept && !pop)
                count <= count + CW'(1);
            else if (!accept && pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (in_mem_write_en && stat_hit)
            ovf <= 1'b0;
        else if (push && !accept)
            ovf <= 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle_cnt <= 32'h0;
        else if (in_mem_write_en && cyc_hit)
            cycle_cnt <= in_mem_write_data;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus_err <= 1'b0;
        else if (unmapped)
            bus_err <= 1'b1;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table for RAM/counter
// behaviour, hand sequences for the console FIFO and bus error.
module tb_mem_responder;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        bus_error;

    int total;
    int passed;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    mem_responder dut (
        .clk               (clk),
        .reset             (reset),
        .in_address_bus    (addr),
        .in_mem_write_en   (we),
        .in_mem_write_data (wdata),
        .out_mem_read_data (rdata),
        .out_con_valid     (con_valid),
        .out_con_data      (con_data),
        .in_con_ready      (con_ready),
        .out_bus_error     (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w,
                         input logic [31:0] d);
        addr  = a;
        we    = w;
        wdata = d;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        reset     = 1'b1;
        con_ready = 1'b0;
        idle();

        vecs[0]  = '{MB + 32'h8, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[1]  = '{MB + 32'h8, 1'b0, 32'h0, 1'b1, 32'h1};
        vecs[2]  = '{MB + 32'h8, 1'b0, 32'h0, 1'b1, 32'h2};
        vecs[3]  = '{32'h10, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
        vecs[4]  = '{32'h10, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
        vecs[5]  = '{32'h10, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{32'h13, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[7]  = '{MB + 32'h8, 1'b1, 32'h1234, 1'b1, 32'h7};
        vecs[8]  = '{MB + 32'h8, 1'b0, 32'h0, 1'b1, 32'h1234};
        vecs[9]  = '{MB + 32'h8, 1'b0, 32'h0, 1'b1, 32'h1235};
        vecs[10] = '{MB + 32'h8, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1236};
        vecs[11] = '{MB + 32'h8, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF};
        vecs[12] = '{MB + 32'h8, 1'b0, 32'h0, 1'b1, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, con_valid}, 32'h0);
        chk("reset_data", {24'b0, con_data}, 32'h0);
        chk("reset_err", {31'b0, bus_error}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].addr, vecs[i].we, vecs[i].wdata);
            #1;
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rd", i), rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_valid", i), {31'b0, con_valid}, 32'h0);
            chk($sformatf("vec%0d_err", i), {31'b0, bus_error}, 32'h0);
            tick();
        end

        drive(MB + 32'h4, 1'b0, 32'h0);
        #1;
        chk("stat_empty", rdata, 32'h0000_0002);
        drive(MB, 1'b0, 32'h0);
        #1;
        chk("con_data_read", rdata, 32'h0);
        tick();

        con_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(MB, 1'b1, 32'h41 + i);
            tick();
            if (i == 0) begin
                chk("first_push_valid", {31'b0, con_valid}, 32'h1);
                chk("first_push_data", {24'b0, con_data}, 32'h41);
            end
        end
        drive(MB + 32'h4, 1'b0, 32'h0);
        #1;
        chk("stat_full", rdata, 32'h0000_1001);
        drive(MB, 1'b1, 32'h51);
        #1;
        chk("stat_before_ovf_push", {24'b0, con_data}, 32'h41);
        tick();
        drive(MB + 32'h4, 1'b0, 32'h0);
        #1;
        chk("stat_ovf", rdata, 32'h0000_1005);
        drive(MB + 32'h4, 1'b1, 32'hFFFF_FFFF);
        tick();
        drive(MB + 32'h4, 1'b0, 32'h0);
        #1;
        chk("stat_ovf_cleared", rdata, 32'h0000_1001);

        idle();
        con_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("drain%0d_valid", i), {31'b0, con_valid}, 32'h1);
            chk($sformatf("drain%0d_data", i), {24'b0, con_data}, 32'h41 + i);
            tick();
        end
        chk("drained_valid", {31'b0, con_valid}, 32'h0);
        chk("drained_data", {24'b0, con_data}, 32'h0);

        con_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(MB, 1'b1, 32'h60 + i);
            tick();
        end
        drive(MB, 1'b1, 32'h99);
        con_ready = 1'b1;
        #1;
        chk("full_pushpop_head", {24'b0, con_data}, 32'h60);
        tick();
        con_ready = 1'b0;
        drive(MB + 32'h4, 1'b0, 32'h0);
        #1;
        chk("full_pushpop_stat", rdata, 32'h0000_1001);
        idle();
        con_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("pp_drain%0d", i), {24'b0, con_data},
                (i == 15) ? 32'h99 : 32'h61 + i);
            tick();
        end
        chk("pp_drained_valid", {31'b0, con_valid}, 32'h0);

        con_ready = 1'b0;
        drive(32'h8000_0000, 1'b0, 32'h0);
        #1;
        chk("unmapped_rd", rdata, 32'h0);
        chk("err_before_edge", {31'b0, bus_error}, 32'h0);
        tick();
        chk("err_set", {31'b0, bus_error}, 32'h1);
        idle();
        repeat (3) tick();
        chk("err_sticky", {31'b0, bus_error}, 32'h1);

        for (int i = 0; i < 3; i++) begin
            drive(MB, 1'b1, 32'hA0 + i);
            tick();
        end
        idle();
        con_ready = 1'b1;
        tick();
        chk("mid_drain_data", {24'b0, con_data}, 32'hA1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_valid", {31'b0, con_valid}, 32'h0);
        chk("rst_data", {24'b0, con_data}, 32'h0);
        chk("rst_err", {31'b0, bus_error}, 32'h0);
        tick();
        reset = 1'b0;
        con_ready = 1'b0;
        drive(MB + 32'h4, 1'b0, 32'h0);
        #1;
        chk("rst_stat", rdata, 32'h0000_0002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
